// File: rtl/ula_arbiter.sv
// ula_arbiter: shares one external 4-bit combinational ALU between N_REQ
// requesters. One operation in flight at a time: IDLE accepts, EXEC lets the
// ALU settle and captures its result, RESP holds the result until consumed.
module ula_arbiter #(
    parameter int N_REQ = 2,
    parameter bit RR    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [4*N_REQ-1:0] req_a,
    input  logic [4*N_REQ-1:0] req_b,
    input  logic [3*N_REQ-1:0] req_op,
    output logic [N_REQ-1:0]   req_ready,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    output logic [2:0]         alu_op,
    input  logic [3:0]         alu_z,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [3:0]         res_data,
    output logic [1:0]         res_id,
    output logic               res_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, next_state;
    logic [1:0]  ptr;
    logic [1:0]  gidx;
    logic        found;
    logic        accept;
    int unsigned start;
    int unsigned idx;

    // Arbitration: first asserted valid found scanning upward from the start index.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = 0;
        start = RR ? int'(ptr) : 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (start + i) % N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gidx  = 2'(idx);
            end
        end
    end

    // Next state and the one-hot accept strobe (only offered in IDLE, never during reset).
    always_comb begin
        next_state = state;
        req_ready  = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (found && !rst) begin
                    req_ready  = N_REQ'(1) << gidx;
                    accept     = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: next_state = RESP;
            RESP: begin
                if (res_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Datapath: latch operands on accept, capture ALU result in EXEC, release in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a  <= req_a[4*gidx +: 4];
                        alu_b  <= req_b[4*gidx +: 4];
                        alu_op <= req_op[3*gidx +: 3];
                        res_id <= gidx;
                        if (RR) ptr <= (int'(gidx) == N_REQ-1) ? 2'd0 : gidx + 2'd1;
                    end
                end
                EXEC: begin
                    res_valid <= 1'b1;
                    if (alu_op >= 3'b101) begin
                        res_data <= '0;
                        res_err  <= 1'b1;
                    end else begin
                        res_data <= alu_z;
                        res_err  <= 1'b0;
                    end
                end
                RESP: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed testbench for ula_arbiter: a round-robin instance (dut) and a
// fixed-priority instance (dut_fp), each driving its own external ALU model.
module tb_ula_arbiter;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, fp_valid, fp_ready;
    logic [4*N-1:0] req_a, req_b;
    logic [3*N-1:0] req_op;
    logic [3:0]     alu_a, alu_b, alu_z, fp_a, fp_b, fp_z;
    logic [2:0]     alu_op, fp_op;
    logic           res_valid, res_ready, res_err, fp_rvalid, fp_rready, fp_err;
    logic [3:0]     res_data, fp_data;
    logic [1:0]     res_id, fp_id;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // External ALU; illegal opcodes give a non-zero value so ignoring it is observable.
    function automatic logic [3:0] alu(input logic [3:0] a, b, input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            default: return 4'h9;
        endcase
    endfunction

    assign alu_z = alu(alu_a, alu_b, alu_op);
    assign fp_z  = alu(fp_a, fp_b, fp_op);

    ula_arbiter #(.N_REQ(N), .RR(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .req_ready(req_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_z(alu_z), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .res_err(res_err)
    );

    ula_arbiter #(.N_REQ(N), .RR(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .req_valid(fp_valid), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .req_ready(fp_ready), .alu_a(fp_a), .alu_b(fp_b),
        .alu_op(fp_op), .alu_z(fp_z), .res_valid(fp_rvalid), .res_ready(fp_rready),
        .res_data(fp_data), .res_id(fp_id), .res_err(fp_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full handshake for one requester; returns res_valid one and two edges after accept.
    task automatic issue(input int id, input logic [3:0] a, b, input logic [2:0] op,
                         output logic to, output logic rv0, rv1,
                         output logic [3:0] d, output logic [1:0] rid, output logic e);
        int n = 0;
        req_a[4*id +: 4]  = a;
        req_b[4*id +: 4]  = b;
        req_op[3*id +: 3] = op;
        req_valid[id]     = 1'b1;
        res_ready         = 1'b1;
        #1;
        while (!req_ready[id] && n < 20) begin
            tick();
            n++;
        end
        to = (n >= 20);
        tick();
        req_valid[id] = 1'b0;
        rv0 = res_valid;
        tick();
        rv1 = res_valid;
        d   = res_data;
        rid = res_id;
        e   = res_err;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; fp_valid = '0; req_a = '0; req_b = '0; req_op = '0;
        res_ready = 1'b0; fp_rready = 1'b1;
        repeat (2) tick();
        checks++;
        if ({req_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_id, res_err} !== '0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b a=%h b=%h op=%h v=%b d=%h id=%0d err=%b, want all 0",
                     req_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_id, res_err);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic to, rv0, rv1, e; logic [3:0] d; logic [1:0] rid;
        issue(0, 4'h3, 4'h4, 3'b000, to, rv0, rv1, d, rid, e);
        checks++;
        if (to) begin errors++; $display("FAIL single_grant: got no grant, want grant"); end
        checks++;
        if ({rv0, rv1} !== 2'b01) begin
            errors++; $display("FAIL single_latency: got valid(N+1,N+2)=%b%b, want 01", rv0, rv1);
        end
        checks++;
        if ({d, rid, e} !== {4'h7, 2'd0, 1'b0}) begin
            errors++; $display("FAIL single_result: got d=%h id=%0d err=%b, want d=7 id=0 err=0", d, rid, e);
        end
    endtask

    task automatic test_wrap();
        logic to, rv0, rv1, e; logic [3:0] d; logic [1:0] rid;
        logic [3:0] va [3] = '{4'hF, 4'h0, 4'hC};
        logic [3:0] vb [3] = '{4'h1, 4'h1, 4'hA};
        logic [2:0] vo [3] = '{3'b000, 3'b001, 3'b100};
        logic [3:0] ve [3] = '{4'h0, 4'hF, 4'h6};
        for (int k = 0; k < 3; k++) begin
            issue(1, va[k], vb[k], vo[k], to, rv0, rv1, d, rid, e);
            checks++;
            if (to || !rv1 || {d, rid, e} !== {ve[k], 2'd1, 1'b0}) begin
                errors++;
                $display("FAIL wrap_%0d: got to=%b v=%b d=%h id=%0d err=%b, want d=%h id=1 err=0",
                         k, to, rv1, d, rid, e, ve[k]);
            end
        end
    endtask

    task automatic test_arbitration();
        int n;
        logic [N-1:0] want;
        req_a = 8'h21; req_b = '0; req_op = '0; res_ready = 1'b1;
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (req_ready === '0 && n < 10) begin tick(); n++; end
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (req_ready !== want) begin
                errors++; $display("FAIL rr_grant_%0d: got %b, want %b", k, req_ready, want);
            end
            tick();
        end
        req_valid = '0;
        repeat (4) tick();
        fp_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (fp_ready === '0 && n < 10) begin tick(); n++; end
            checks++;
            if (fp_ready !== 2'b01) begin
                errors++; $display("FAIL fixed_grant_%0d: got %b, want 01", k, fp_ready);
            end
            tick();
        end
        fp_valid = '0;
        repeat (4) tick();
    endtask

    task automatic test_back_pressure();
        int n = 0;
        req_a = 8'h52; req_b = 8'h13; req_op = {3'b001, 3'b011};
        res_ready = 1'b0;
        req_valid = 2'b01;
        #1;
        while (!req_ready[0] && n < 10) begin tick(); n++; end
        tick();
        req_valid = 2'b10;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({res_valid, res_data, res_id, res_err, req_ready} !== {1'b1, 4'h3, 2'd0, 1'b0, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%b d=%h id=%0d err=%b ready=%b, want v=1 d=3 id=0 err=0 ready=00",
                         k, res_valid, res_data, res_id, res_err, req_ready);
            end
            tick();
        end
        res_ready = 1'b1;
        tick();
        checks++;
        if (req_ready !== 2'b10 || res_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: got ready=%b v=%b, want ready=10 v=0", req_ready, res_valid);
        end
        tick();
        req_valid = '0;
        tick();
        checks++;
        if ({res_valid, res_data, res_id} !== {1'b1, 4'h4, 2'd1}) begin
            errors++; $display("FAIL bp_next: got v=%b d=%h id=%0d, want v=1 d=4 id=1", res_valid, res_data, res_id);
        end
        tick();
    endtask

    task automatic test_illegal();
        logic to, rv0, rv1, e; logic [3:0] d; logic [1:0] rid;
        issue(0, 4'h5, 4'h5, 3'b110, to, rv0, rv1, d, rid, e);
        checks++;
        if (to || !rv1 || {d, e} !== {4'h0, 1'b1}) begin
            errors++; $display("FAIL illegal_op: got v=%b d=%h err=%b, want d=0 err=1", rv1, d, e);
        end
        issue(1, 4'h5, 4'h5, 3'b000, to, rv0, rv1, d, rid, e);
        checks++;
        if (to || !rv1 || {d, e} !== {4'hA, 1'b0}) begin
            errors++; $display("FAIL legal_after_illegal: got v=%b d=%h err=%b, want d=a err=0", rv1, d, e);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        req_a = 8'h17; req_b = 8'h11; req_op = '0; res_ready = 1'b0;
        req_valid = 2'b11;
        #1;
        while (req_ready === '0 && n < 10) begin tick(); n++; end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({res_valid, alu_a, alu_b, alu_op, req_ready} !== '0) begin
            errors++; $display("FAIL rst_exec: got v=%b a=%h b=%h op=%h ready=%b, want all 0",
                               res_valid, alu_a, alu_b, alu_op, req_ready);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL rst_exec_regrant: got %b, want 01", req_ready);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({res_valid, res_data} !== {1'b1, 4'h8}) begin
            errors++; $display("FAIL rst_resp_pre: got v=%b d=%h, want v=1 d=8", res_valid, res_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({res_valid, res_data, res_id, alu_a, alu_b, alu_op, req_ready} !== '0) begin
            errors++; $display("FAIL rst_resp: got v=%b d=%h id=%0d a=%h b=%h op=%h ready=%b, want all 0",
                               res_valid, res_data, res_id, alu_a, alu_b, alu_op, req_ready);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL rst_resp_regrant: got %b, want 01", req_ready);
        end
        req_valid = '0;
        res_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_arbitration();
        test_back_pressure();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1);
    end

endmodule
